// File: rtl/bus_arbiter_pkg.sv
// Shared types and constants for the ibus/dbus memory-port arbiter.
package bus_arbiter_pkg;

  // Arbiter FSM encoding (2 bits).
  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_ISSUE = 2'd1,
    ARB_WAIT  = 2'd2
  } arb_state_e;

  // Owner of the single in-flight transaction.
  typedef enum logic {
    ARB_OWN_I = 1'b0,
    ARB_OWN_D = 1'b1
  } arb_owner_e;

  // Consecutive dbus wins tolerated while ibus is waiting.
  localparam int ARB_STARVE_MAX = 3;

endpackage

// File: rtl/bus_arbiter.sv
// Shares one memory port between instruction fetch (ibus) and load/store (dbus).
// One transaction in flight at a time; dbus has priority, ibus is forced after
// STARVE_MAX consecutive dbus wins while it waits.
//
// Handshakes: a master raises req with a stable command and holds it until its
// ack pulse (one cycle, rdata valid in that cycle and held afterwards). Towards
// memory, O_mem_req and the command stay stable until the cycle I_mem_gnt is
// high; exactly one I_mem_rvalid follows each grant, never in the grant cycle.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MASK_W     = 4,
  parameter int STARVE_MAX = ARB_STARVE_MAX,
  localparam int CNT_W     = $clog2(STARVE_MAX + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              I_ibus_req,
  input  logic [ADDR_W-1:0] I_ibus_addr,
  input  logic              I_ibus_flush,
  output logic              O_ibus_ack,
  output logic [DATA_W-1:0] O_ibus_rdata,
  output logic              O_ibus_stallreq,
  input  logic              I_dbus_req,
  input  logic              I_dbus_we,
  input  logic [ADDR_W-1:0] I_dbus_addr,
  input  logic [DATA_W-1:0] I_dbus_wdata,
  input  logic [MASK_W-1:0] I_dbus_mask,
  output logic              O_dbus_ack,
  output logic [DATA_W-1:0] O_dbus_rdata,
  output logic              O_dbus_stallreq,
  output logic              O_mem_req,
  output logic              O_mem_we,
  output logic [ADDR_W-1:0] O_mem_addr,
  output logic [DATA_W-1:0] O_mem_wdata,
  output logic [MASK_W-1:0] O_mem_mask,
  input  logic              I_mem_gnt,
  input  logic              I_mem_rvalid,
  input  logic [DATA_W-1:0] I_mem_rdata,
  output arb_state_e        dbg_state,
  output logic [CNT_W-1:0]  dbg_starve_cnt
);

  localparam logic [CNT_W-1:0] STARVE_LIM = CNT_W'(STARVE_MAX);

  arb_state_e        state_q, state_d;
  arb_owner_e        owner_q;
  logic              cmd_we_q;
  logic [ADDR_W-1:0] cmd_addr_q;
  logic [DATA_W-1:0] cmd_wdata_q;
  logic [MASK_W-1:0] cmd_mask_q;
  logic [CNT_W-1:0]  starve_q;
  logic              drop_q;
  logic [DATA_W-1:0] ibus_rdata_q;
  logic [DATA_W-1:0] dbus_rdata_q;

  logic pick_i, pick_d;
  logic complete, flush_hit, drop_now;

  // Next-state and arbitration decision.
  always_comb begin
    state_d = state_q;
    pick_i  = 1'b0;
    pick_d  = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (I_dbus_req && (!I_ibus_req || (starve_q < STARVE_LIM))) begin
          pick_d = 1'b1;
        end else if (I_ibus_req) begin
          pick_i = 1'b1;
        end
        if (pick_i || pick_d) state_d = ARB_ISSUE;
      end
      ARB_ISSUE: if (I_mem_gnt)    state_d = ARB_WAIT;
      ARB_WAIT:  if (I_mem_rvalid) state_d = ARB_IDLE;
      default:   state_d = ARB_IDLE;
    endcase
  end

  // Completion and flush qualification; a flush in the rvalid cycle still drops.
  always_comb begin
    complete  = (state_q == ARB_WAIT) && I_mem_rvalid;
    flush_hit = I_ibus_flush && (owner_q == ARB_OWN_I) &&
                ((state_q == ARB_ISSUE) || (state_q == ARB_WAIT));
    drop_now  = drop_q || flush_hit;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ARB_IDLE;
    else        state_q <= state_d;
  end

  // Command capture from the arbitration winner.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q     <= ARB_OWN_I;
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      cmd_mask_q  <= '0;
    end else if (pick_d) begin
      owner_q     <= ARB_OWN_D;
      cmd_we_q    <= I_dbus_we;
      cmd_addr_q  <= I_dbus_addr;
      cmd_wdata_q <= I_dbus_wdata;
      cmd_mask_q  <= I_dbus_mask;
    end else if (pick_i) begin
      owner_q     <= ARB_OWN_I;
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= I_ibus_addr;
      cmd_wdata_q <= '0;
      cmd_mask_q  <= '1;
    end
  end

  // Starvation counter: counts dbus wins over a waiting ibus, cleared on ibus win.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_q <= '0;
    end else if (pick_d && I_ibus_req) begin
      if (starve_q != STARVE_LIM) starve_q <= starve_q + CNT_W'(1);
    end else if (pick_i) begin
      starve_q <= '0;
    end
  end

  // Drop flag for a fetch flushed while in flight; consumed by its completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         drop_q <= 1'b0;
    else if (complete)  drop_q <= 1'b0;
    else if (flush_hit) drop_q <= 1'b1;
  end

  // Read-data holding registers, updated only on a delivered ack so the
  // value a master sees stays put until its next ack.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ibus_rdata_q <= '0;
      dbus_rdata_q <= '0;
    end else begin
      if (O_ibus_ack) ibus_rdata_q <= I_mem_rdata;
      if (O_dbus_ack) dbus_rdata_q <= I_mem_rdata;
    end
  end

  // Output decode: acks and rdata bypass in the rvalid cycle, memory command from cmd regs.
  always_comb begin
    O_ibus_ack      = complete && (owner_q == ARB_OWN_I) && !drop_now;
    O_dbus_ack      = complete && (owner_q == ARB_OWN_D);
    O_ibus_rdata    = O_ibus_ack ? I_mem_rdata : ibus_rdata_q;
    O_dbus_rdata    = O_dbus_ack ? I_mem_rdata : dbus_rdata_q;
    O_ibus_stallreq = I_ibus_req && !O_ibus_ack;
    O_dbus_stallreq = I_dbus_req && !O_dbus_ack;
    O_mem_req       = (state_q == ARB_ISSUE);
    O_mem_we        = cmd_we_q;
    O_mem_addr      = cmd_addr_q;
    O_mem_wdata     = cmd_wdata_q;
    O_mem_mask      = cmd_mask_q;
    dbg_state       = state_q;
    dbg_starve_cnt  = starve_q;
  end

  // Memory must never grant and respond in the same ISSUE cycle.
  a_no_gnt_rvalid : assert property (@(posedge clk) disable iff (!rst_n)
    !((state_q == ARB_ISSUE) && I_mem_gnt && I_mem_rvalid));

endmodule
